// File: rtl/sram_data_responder_pkg.sv
// Shared types and defaults for the SRAM data responder: state encoding,
// SRAM geometry and word width (taken from REGISTER_LEN when the core defines it).
`ifndef REGISTER_LEN
`define REGISTER_LEN 32
`endif

package sram_data_responder_pkg;

  localparam int WORD_W          = `REGISTER_LEN;
  localparam int SRAM_DATA_W     = 16;
  localparam int SRAM_ADDR_W_DEF = 18;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam logic [WORD_W-1:0] ADDR_BASE_DEF = WORD_W'(1024);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR_LO = 3'd3,
    ST_WR_HI = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic is_write_phase(state_t s);
    return (s == ST_WR_LO) || (s == ST_WR_HI);
  endfunction

  function automatic logic is_read_phase(state_t s);
    return (s == ST_RD_LO) || (s == ST_RD_HI);
  endfunction

endpackage

// File: rtl/sram_data_responder_if.sv
// Data-memory request interface between the MEM stage (master) and the
// SRAM data responder (slave).
interface sram_data_responder_if;
  import sram_data_responder_pkg::*;

  // Handshake: the master raises mem_read_in or mem_write_in and holds it,
  // together with addr_in/write_data_in, stable until it samples ready_out=1
  // on a rising clock edge; that edge completes the transfer. ready_out=1 with
  // no request pending means idle, and no transfer happens.
  logic              mem_read_in;
  logic              mem_write_in;
  logic [WORD_W-1:0] addr_in;
  logic [WORD_W-1:0] write_data_in;
  logic [WORD_W-1:0] read_data_out;
  logic              ready_out;

  modport master (
    output mem_read_in,
    output mem_write_in,
    output addr_in,
    output write_data_in,
    input  read_data_out,
    input  ready_out
  );

  modport slave (
    input  mem_read_in,
    input  mem_write_in,
    input  addr_in,
    input  write_data_in,
    output read_data_out,
    output ready_out
  );

endinterface

// File: rtl/sram_phase_timer.sv
// Per-phase wait counter: load clears it, en counts it up, and tc flags the
// last cycle of a phase (count == WAIT_CYCLES-1).
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/sram_data_responder.sv
// Serves 32-bit MEM-stage loads/stores from a 16-bit asynchronous SRAM in two
// half-word phases. Optional last-read buffer: define SRAM_LAST_READ_BUF_EN.
module sram_data_responder
  import sram_data_responder_pkg::*;
#(
  parameter logic [WORD_W-1:0] ADDR_BASE   = ADDR_BASE_DEF,
  parameter int                WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int                SRAM_ADDR_W = SRAM_ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_data_responder_if.slave   mem,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n,
  output state_t                 dbg_state
);

  state_t state, state_nxt;

  logic                   phase_last;
  logic                   timer_load;
  logic                   timer_en;
  logic                   cap_lo;
  logic                   cap_hi;
  logic                   wr_done;
  logic                   buf_take;
  logic                   buf_hit;
  logic [WORD_W-1:0]      rdata;
  logic [WORD_W-1:0]      addr_off;
  logic [SRAM_ADDR_W-2:0] word_idx;
  logic [SRAM_ADDR_W-1:0] lo_addr;
  logic [SRAM_ADDR_W-1:0] hi_addr;
  logic                   unused_addr_bits;

  // Byte offset to half-word pair; out-of-range upper bits simply wrap.
  assign addr_off = mem.addr_in - ADDR_BASE;
  assign word_idx = addr_off[SRAM_ADDR_W:2];
  assign lo_addr  = {word_idx, 1'b0};
  assign hi_addr  = {word_idx, 1'b1};
  assign unused_addr_bits = ^{addr_off[WORD_W-1:SRAM_ADDR_W+1], addr_off[1:0]};

  sram_phase_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (timer_en),
    .tc   (phase_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_load  = 1'b0;
    timer_en    = 1'b0;
    cap_lo      = 1'b0;
    cap_hi      = 1'b0;
    wr_done     = 1'b0;
    buf_take    = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      ST_IDLE: begin
        timer_load = 1'b1;
        if (mem.mem_write_in) begin
          state_nxt = ST_WR_LO;
        end else if (mem.mem_read_in) begin
          buf_take  = buf_hit;
          state_nxt = buf_hit ? ST_DONE : ST_RD_LO;
        end
      end
      ST_RD_LO, ST_RD_HI: begin
        sram_addr = (state == ST_RD_LO) ? lo_addr : hi_addr;
        timer_en  = 1'b1;
        if (phase_last) begin
          timer_load = 1'b1;
          cap_lo     = (state == ST_RD_LO);
          cap_hi     = (state == ST_RD_HI);
          state_nxt  = (state == ST_RD_LO) ? ST_RD_HI : ST_DONE;
        end
      end
      ST_WR_LO, ST_WR_HI: begin
        sram_addr   = (state == ST_WR_LO) ? lo_addr : hi_addr;
        sram_dq_out = (state == ST_WR_LO) ? mem.write_data_in[15:0]
                                          : mem.write_data_in[31:16];
        sram_dq_oe  = 1'b1;
        // WE rises on the last phase cycle so address and data outlive it.
        sram_we_n   = phase_last;
        timer_en    = 1'b1;
        if (phase_last) begin
          timer_load = 1'b1;
          wr_done    = (state == ST_WR_HI);
          state_nxt  = (state == ST_WR_LO) ? ST_WR_HI : ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef SRAM_LAST_READ_BUF_EN
  logic                   buf_valid;
  logic [SRAM_ADDR_W-2:0] buf_word;
  logic [WORD_W-1:0]      buf_data;

  assign buf_hit = buf_valid && (buf_word == word_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_word  <= '0;
      buf_data  <= '0;
    end else if (cap_hi) begin
      buf_valid <= 1'b1;
      buf_word  <= word_idx;
      buf_data  <= {sram_dq_in, rdata[15:0]};
    end else if (wr_done && buf_hit) begin
      buf_data  <= mem.write_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (cap_lo) begin
      rdata[15:0] <= sram_dq_in;
    end else if (cap_hi) begin
      rdata[31:16] <= sram_dq_in;
    end else if (buf_take) begin
      rdata <= buf_data;
    end
  end
`else
  logic unused_buf_sigs;

  assign buf_hit         = 1'b0;
  assign unused_buf_sigs = wr_done ^ buf_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (cap_lo) begin
      rdata[15:0] <= sram_dq_in;
    end else if (cap_hi) begin
      rdata[31:16] <= sram_dq_in;
    end
  end
`endif

  assign mem.read_data_out = rdata;
  assign mem.ready_out     = ~(mem.mem_read_in | mem.mem_write_in) | (state == ST_DONE);
  assign dbg_state         = state;

endmodule

// File: tb/tb_sram_data_responder.sv
// Directed bench for sram_data_responder against a small behavioural SRAM
// that latches writes on the rising edge of sram_we_n.
module tb_sram_data_responder;
  import sram_data_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  state_t      dbg_state;

  sram_data_responder_if mem_if ();

  sram_data_responder dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (mem_if.slave),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: 256 half-words, write committed when WE rises.
  logic [15:0] sram_mem [0:255];
  logic        unused_hi;
  assign sram_dq_in = sram_mem[sram_addr[7:0]];
  assign unused_hi  = ^sram_addr[17:8];
  always @(posedge sram_we_n) begin
    if (sram_dq_oe === 1'b1) sram_mem[sram_addr[7:0]] <= sram_dq_out;
  end

  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic        we_log    [0:15];
  logic        oe_log    [0:15];
  logic        ready_log [0:15];
  logic [17:0] addr_log  [0:15];
  logic [15:0] dqo_log   [0:15];
  logic [31:0] rdata_log [0:15];

  // Driver: call at a falling edge; returns at the falling edge after DONE.
  task automatic do_access(input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
    for (int c = 0; c < 16; c++) begin
      we_log[c] = 1'bx; oe_log[c] = 1'bx; ready_log[c] = 1'bx;
      addr_log[c] = 'x; dqo_log[c] = 'x; rdata_log[c] = 'x;
    end
    mem_if.mem_read_in   = rd;
    mem_if.mem_write_in  = wr;
    mem_if.addr_in       = a;
    mem_if.write_data_in = d;
    lat = -1;
    for (int c = 0; c < 16; c++) begin
      #1;
      we_log[c]    = sram_we_n;
      oe_log[c]    = sram_dq_oe;
      ready_log[c] = mem_if.ready_out;
      addr_log[c]  = sram_addr;
      dqo_log[c]   = sram_dq_out;
      rdata_log[c] = mem_if.read_data_out;
      if (mem_if.ready_out === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    mem_if.mem_read_in  = 1'b0;
    mem_if.mem_write_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (mem_if.ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", mem_if.ready_out); end
    checks++; if (mem_if.read_data_out !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", mem_if.read_data_out); end
    checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr got %h want 0", sram_addr); end
    checks++; if (sram_dq_out !== 16'h0) begin errors++; $display("FAIL reset_dq_out got %h want 0", sram_dq_out); end
    checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", sram_dq_oe); end
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b want 1", sram_we_n); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    checks++; if (lat !== 5) begin errors++; $display("FAIL wr_latency got %0d want 5", lat); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (ready_log[c] !== 1'b0) begin errors++; $display("FAIL wr_ready_c%0d got %b want 0", c, ready_log[c]); end
    end
    for (int c = 1; c < 5; c++) begin
      checks++; if (we_log[c] !== (c % 2 == 0)) begin errors++; $display("FAIL wr_we_n_c%0d got %b want %b", c, we_log[c], (c % 2 == 0)); end
      checks++; if (addr_log[c] !== ((c >= 3) ? 18'd1 : 18'd0)) begin errors++; $display("FAIL wr_addr_c%0d got %h want %h", c, addr_log[c], (c >= 3) ? 18'd1 : 18'd0); end
      checks++; if (dqo_log[c] !== ((c >= 3) ? 16'hDEAD : 16'hBEEF)) begin errors++; $display("FAIL wr_dq_c%0d got %h want %h", c, dqo_log[c], (c >= 3) ? 16'hDEAD : 16'hBEEF); end
      checks++; if (oe_log[c] !== 1'b1) begin errors++; $display("FAIL wr_oe_c%0d got %b want 1", c, oe_log[c]); end
    end
    checks++; if (we_log[0] !== 1'b1) begin errors++; $display("FAIL wr_we_n_idle got %b want 1", we_log[0]); end
    checks++; if (sram_mem[0] !== 16'hBEEF) begin errors++; $display("FAIL wr_mem0 got %h want beef", sram_mem[0]); end
    checks++; if (sram_mem[1] !== 16'hDEAD) begin errors++; $display("FAIL wr_mem1 got %h want dead", sram_mem[1]); end
    checks++; if (mem_if.read_data_out !== 32'h0) begin errors++; $display("FAIL wr_rdata_kept got %h want 0", mem_if.read_data_out); end
  endtask

  task automatic test_read();
    do_access(1'b1, 1'b0, 32'd1024, 32'h0);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rd_latency got %0d want 5", lat); end
    checks++; if (rdata_log[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rdata_log[5]); end
    for (int c = 0; c < 6; c++) begin
      checks++; if (oe_log[c] !== 1'b0 || we_log[c] !== 1'b1) begin errors++; $display("FAIL rd_bus_c%0d got oe=%b we_n=%b want oe=0 we_n=1", c, oe_log[c], we_log[c]); end
    end
    checks++; if (addr_log[1] !== 18'd0 || addr_log[3] !== 18'd1) begin errors++; $display("FAIL rd_addr got %h/%h want 0/1", addr_log[1], addr_log[3]); end
  endtask

  task automatic test_back_to_back();
    time t0, t1;
    do_access(1'b0, 1'b1, 32'd1028, 32'h12345678);
    checks++; if (sram_mem[2] !== 16'h5678 || sram_mem[3] !== 16'h1234) begin errors++; $display("FAIL b2b_wr_mem got %h/%h want 5678/1234", sram_mem[2], sram_mem[3]); end
    t0 = $time;
    do_access(1'b1, 1'b0, 32'd1024, 32'h0);
    t1 = $time;
    checks++; if (lat !== 5 || rdata_log[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rd0 got lat=%0d data=%h want lat=5 data=deadbeef", lat, rdata_log[5]); end
    checks++; if ((t1 - t0) !== 60) begin errors++; $display("FAIL b2b_period got %0t want 60", t1 - t0); end
    do_access(1'b1, 1'b0, 32'd1028, 32'h0);
    checks++; if (lat !== 5 || rdata_log[5] !== 32'h12345678) begin errors++; $display("FAIL b2b_rd1 got lat=%0d data=%h want lat=5 data=12345678", lat, rdata_log[5]); end
    checks++; if (addr_log[1] !== 18'd2 || addr_log[3] !== 18'd3) begin errors++; $display("FAIL b2b_rd1_addr got %h/%h want 2/3", addr_log[1], addr_log[3]); end
  endtask

  task automatic test_both_requests();
    do_access(1'b1, 1'b1, 32'd1032, 32'h0000CAFE);
    checks++; if (lat !== 5) begin errors++; $display("FAIL both_latency got %0d want 5", lat); end
    checks++; if (oe_log[1] !== 1'b1 || we_log[1] !== 1'b0) begin errors++; $display("FAIL both_is_write got oe=%b we_n=%b want 1/0", oe_log[1], we_log[1]); end
    checks++; if (sram_mem[4] !== 16'hCAFE || sram_mem[5] !== 16'h0000) begin errors++; $display("FAIL both_mem got %h/%h want cafe/0000", sram_mem[4], sram_mem[5]); end
    checks++; if (mem_if.read_data_out !== 32'h12345678) begin errors++; $display("FAIL both_rdata got %h want 12345678", mem_if.read_data_out); end
  endtask

  task automatic test_reset_mid_write();
    bit seen = 1'b0;
    mem_if.mem_write_in  = 1'b1;
    mem_if.addr_in       = 32'd1040;
    mem_if.write_data_in = 32'h11112222;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (dbg_state === ST_WR_HI) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_reach got state=%0d want WR_HI", dbg_state); end
    checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL rstmid_pre_we_n got %b want 0", sram_we_n); end
    rst = 1'b0;
    mem_if.mem_write_in = 1'b0;
    #1;
    checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin errors++; $display("FAIL rstmid_we_oe got we_n=%b oe=%b want 1/0", sram_we_n, sram_dq_oe); end
    checks++; if (sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin errors++; $display("FAIL rstmid_bus got addr=%h dq=%h want 0/0", sram_addr, sram_dq_out); end
    checks++; if (mem_if.read_data_out !== 32'h0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstmid_state got rdata=%h state=%0d want 0/IDLE", mem_if.read_data_out, dbg_state); end
    checks++; if (mem_if.ready_out !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", mem_if.ready_out); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0);
    checks++; if (lat !== 5 || rdata_log[5] !== 32'h12345678) begin errors++; $display("FAIL rstmid_rd got lat=%0d data=%h want lat=5 data=12345678", lat, rdata_log[5]); end
  endtask

  task automatic test_last_read_buf();
    int exp_lat;
`ifdef SRAM_LAST_READ_BUF_EN
    exp_lat = 1;
`else
    exp_lat = 5;
`endif
    do_access(1'b1, 1'b0, 32'd1028, 32'h0);
    checks++; if (lat !== exp_lat || rdata_log[exp_lat] !== 32'h12345678) begin errors++; $display("FAIL buf_repeat got lat=%0d data=%h want lat=%0d data=12345678", lat, rdata_log[exp_lat], exp_lat); end
`ifdef SRAM_LAST_READ_BUF_EN
    checks++; if (addr_log[0] !== 18'd0 || addr_log[1] !== 18'd0 || oe_log[1] !== 1'b0) begin errors++; $display("FAIL buf_quiet got addr=%h/%h oe=%b want 0/0/0", addr_log[0], addr_log[1], oe_log[1]); end
`else
    checks++; if (addr_log[1] !== 18'd2 || addr_log[3] !== 18'd3) begin errors++; $display("FAIL buf_sram_addr got %h/%h want 2/3", addr_log[1], addr_log[3]); end
`endif
    do_access(1'b0, 1'b1, 32'd1028, 32'hA5A55A5A);
    checks++; if (lat !== 5) begin errors++; $display("FAIL buf_wr_latency got %0d want 5", lat); end
    do_access(1'b1, 1'b0, 32'd1028, 32'h0);
    checks++; if (lat !== exp_lat || rdata_log[exp_lat] !== 32'hA5A55A5A) begin errors++; $display("FAIL buf_after_wr got lat=%0d data=%h want lat=%0d data=a5a55a5a", lat, rdata_log[exp_lat], exp_lat); end
    do_access(1'b1, 1'b0, 32'd1024, 32'h0);
    checks++; if (lat !== 5 || rdata_log[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL buf_miss got lat=%0d data=%h want lat=5 data=deadbeef", lat, rdata_log[5]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0;
    sram_mem[5]          = 16'hFFFF;
    rst                  = 1'b0;
    mem_if.mem_read_in   = 1'b0;
    mem_if.mem_write_in  = 1'b0;
    mem_if.addr_in       = 32'h0;
    mem_if.write_data_in = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_both_requests();
    test_reset_mid_write();
    test_last_read_buf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_data_responder.md
Name: sram_data_responder

Overview:
- Responder end of the data-memory request interface driven by the MEM stage: accepts one 32-bit read or write per request.
- Serves each request from an external 16-bit asynchronous SRAM as two half-word phases.
- Holds `ready_out` low while busy; the hazard/freeze logic stalls the pipeline on it.
- Sits between the MEM stage and the board SRAM pins; replaces the single-cycle data memory.

Parameters:
- ADDR_BASE, 1024: byte address that maps to SRAM word 0; subtracted before translation.
- WAIT_CYCLES, 2: cycles each SRAM phase is held (≥1); covers SRAM access time.
- SRAM_ADDR_W, 18: external SRAM half-word address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read_in  in  1  read request; held stable by the initiator until ready_out=1.
- mem_write_in  in  1  write request; held stable likewise.
- addr_in  in  32  byte address (ALU result), word aligned.
- write_data_in  in  32  store data.
- read_data_out  out  32  loaded word, registered.
- ready_out  out  1  1 = no pending work or access completing this cycle.
- sram_addr  out  SRAM_ADDR_W  half-word address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_oe  out  1  1 = controller drives DQ (top level builds the tristate).
- sram_dq_in  in  16  data from SRAM.
- sram_we_n  out  1  active-low write enable.

Behaviour:
- Reset (rst=0, async):
  - State = IDLE, phase counter = 0.
  - read_data_out = 0, sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, sram_we_n = 1.
- ready_out is combinational: `~(mem_read_in|mem_write_in) | (state==DONE)`. It is therefore 1 during reset when no request is asserted.
- Address translation: `word = (addr_in - ADDR_BASE) >> 2`.
  - Low half at `{word[SRAM_ADDR_W-2:0],0}`, high half at that address + 1.
  - addr_in[1:0] are ignored.
  - Upper bits are truncated (wrap-around); no error flag.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE:
  - mem_write_in=1 → WR_LO. Write wins if both requests are asserted.
  - Else mem_read_in=1 → RD_LO.
  - Else stay.
  - Counter loads 0 on leaving IDLE.
- RD_LO / RD_HI:
  - sram_dq_oe=0, sram_we_n=1, sram_addr = low/high address.
  - Counter increments each cycle.
  - On the cycle counter == WAIT_CYCLES-1, sram_dq_in is captured into read_data_out[15:0] (RD_LO) or [31:16] (RD_HI), and the state advances: RD_LO→RD_HI, RD_HI→DONE.
- WR_LO / WR_HI:
  - sram_dq_oe=1, sram_dq_out = write_data_in[15:0] / [31:16], sram_addr = low/high address.
  - sram_we_n=0 for every phase cycle except the last; it is 1 on the last cycle so data and address hold past the WE rising edge.
  - Advance rules match the read phases: WR_LO→WR_HI→DONE.
- DONE: lasts exactly one cycle (ready_out=1, pipeline advances), then → IDLE unconditionally. A new request is accepted the following cycle.
- Latency: request first seen at cycle 0 in IDLE; ready_out=1 at cycle 2·WAIT_CYCLES+1. Default: cycle 5.
- read_data_out holds its value until the next read overwrites it. Writes never change it.
- A request withdrawn mid-access (illegal) does not abort the access; the FSM completes the sequence.
- Reset mid-access aborts immediately to the reset values. A partial write may leave SRAM half-updated; this is accepted.

Optional Feature:
- Macro: SRAM_LAST_READ_BUF_EN.
- With it: a one-entry buffer holds {valid, word address, data} of the last completed read.
  - Read in IDLE with valid and matching word → DONE next cycle (ready at cycle 1), read_data_out loaded from the buffer, SRAM untouched.
  - A completed write to the matching word updates the buffer data.
  - Reset clears valid.
- Without it: every read performs both SRAM phases.

Decomposition:
- Shared package/defines: state encodings, SRAM data width 16, SRAM_ADDR_W default, ADDR_BASE default, word width from the existing REGISTER_LEN define.
- One natural sub-module: sram_phase_timer, a counter with load/enable and terminal-count output = WAIT_CYCLES-1.

Test Plan:
- Write 0xDEADBEEF to addr 1024 (WAIT_CYCLES=2) → SRAM model sees 0xBEEF at half-addr 0, 0xDEAD at 1; ready_out=0 cycles 0–4, 1 at cycle 5; sram_we_n pattern per phase is 0,1.
- Read addr 1024 after the write → read_data_out=0xDEADBEEF with ready_out=1 at cycle 5; sram_dq_oe=0 throughout.
- Write 0x12345678 to 1028, then read 1024 and 1028 back-to-back → 0xDEADBEEF then 0x12345678; each request takes 6 cycles including the DONE→IDLE return.
- mem_read_in=mem_write_in=1 at addr 1032, data 0x0000CAFE → write performed, read_data_out unchanged.
- Reset pulse during WR_HI → outputs at reset values within the same cycle (async); sram_we_n=1; next request starts from IDLE normally.
- With SRAM_LAST_READ_BUF_EN: repeat read of 1028 → ready_out=1 at cycle 1, no SRAM address activity.
